adt7420_read_sequencer: RTL and testbench

- Command sequencer directly upstream of the I2C byte driver.
- Issues the step commands and transmit bytes that read the 16-bit temperature register of the ADT7420 sensor.
- Collects the two received bytes and presents one temperature word with status flags to the LED/host logic.
- Owns all protocol ordering; the driver only executes one step at a time.

---
 rtl/adt7420_read_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_adt7420_read_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_read_sequencer.sv
// rtl/adt7420_read_sequencer.sv - step sequencer reading the ADT7420 16-bit temperature register.
// Optional build macro AUTO_POLL_EN adds a free-running internal start every POLL_CYCLES clocks.
module adt7420_read_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h48,
  parameter logic [7:0]  REG_ADDR       = 8'h00,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
  parameter logic [23:0] POLL_CYCLES    = 24'd10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [1:0]  drv_step,
  output logic [7:0]  drv_tx_byte,
  output logic        drv_rx_nack,
  input  logic        drv_ready,
  input  logic        drv_ack,
  input  logic [7:0]  drv_rx_byte,
  output logic [15:0] temp_raw,
  output logic        temp_valid,
  output logic        nack_err,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    IDLE,
    START1,
    WADDR,
    WREG,
    START2,
    RADDR,
    RXMSB,
    RXLSB,
    STOP,
    DONE,
    ERR_STOP
  } state_t;

  localparam logic [1:0] STEP_STOP  = 2'b00;
  localparam logic [1:0] STEP_START = 2'b01;
  localparam logic [1:0] STEP_TX    = 2'b10;
  localparam logic [1:0] STEP_RX    = 2'b11;

  state_t      state;
  state_t      state_nx;
  state_t      step_next;
  logic [19:0] tcnt;
  logic [7:0]  msb;
  logic [7:0]  lsb;
  logic        start_req;
  logic        accept;
  logic        waiting;
  logic        ack_chk;
  logic        timed_out;
  logic        set_nack;
  logic        set_to;

`ifdef AUTO_POLL_EN
  logic [23:0] poll_cnt;
  logic        poll_tick;

  assign poll_tick = (poll_cnt == POLL_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= 24'd0;
    end else if (poll_tick) begin
      poll_cnt <= 24'd0;
    end else begin
      poll_cnt <= poll_cnt + 24'd1;
    end
  end

  assign start_req = start | poll_tick;
`else
  assign start_req = start;
`endif

  assign timed_out = (tcnt == TIMEOUT_CYCLES - 20'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= 20'd0;
      msb         <= 8'h00;
      lsb         <= 8'h00;
      temp_raw    <= 16'h0000;
      nack_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      // Each newly issued command starts its own timeout window.
      if (waiting && state_nx == state) begin
        tcnt <= tcnt + 20'd1;
      end else begin
        tcnt <= 20'd0;
      end
      if (accept) begin
        nack_err    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (set_nack) begin
        nack_err <= 1'b1;
      end
      if (set_to) begin
        timeout_err <= 1'b1;
      end
      if (state == RXMSB && drv_ready) begin
        msb <= drv_rx_byte;
      end
      if (state == RXLSB && drv_ready) begin
        lsb <= drv_rx_byte;
      end
      // Loaded while leaving STOP so the word is stable during the DONE pulse.
      if (state == STOP) begin
        temp_raw <= {msb, lsb};
      end
    end
  end

  always_comb begin
    state_nx    = state;
    step_next   = IDLE;
    drv_step    = STEP_STOP;
    drv_tx_byte = 8'h00;
    drv_rx_nack = 1'b0;
    busy        = (state != IDLE);
    temp_valid  = 1'b0;
    accept      = 1'b0;
    waiting     = 1'b0;
    ack_chk     = 1'b0;
    set_nack    = 1'b0;
    set_to      = 1'b0;

    case (state)
      IDLE: begin
        if (start_req) begin
          accept   = 1'b1;
          state_nx = START1;
        end
      end
      START1: begin
        drv_step  = STEP_START;
        waiting   = 1'b1;
        step_next = WADDR;
      end
      WADDR: begin
        drv_step    = STEP_TX;
        drv_tx_byte = {DEV_ADDR, 1'b0};
        waiting     = 1'b1;
        ack_chk     = 1'b1;
        step_next   = WREG;
      end
      WREG: begin
        drv_step    = STEP_TX;
        drv_tx_byte = REG_ADDR;
        waiting     = 1'b1;
        ack_chk     = 1'b1;
        step_next   = START2;
      end
      START2: begin
        drv_step  = STEP_START;
        waiting   = 1'b1;
        step_next = RADDR;
      end
      RADDR: begin
        drv_step    = STEP_TX;
        drv_tx_byte = {DEV_ADDR, 1'b1};
        waiting     = 1'b1;
        ack_chk     = 1'b1;
        step_next   = RXMSB;
      end
      RXMSB: begin
        drv_step    = STEP_RX;
        drv_rx_nack = 1'b0;
        waiting     = 1'b1;
        step_next   = RXLSB;
      end
      RXLSB: begin
        drv_step    = STEP_RX;
        drv_rx_nack = 1'b1;
        waiting     = 1'b1;
        step_next   = STOP;
      end
      STOP: begin
        state_nx = DONE;
      end
      DONE: begin
        temp_valid = 1'b1;
        state_nx   = IDLE;
      end
      ERR_STOP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (waiting) begin
      if (drv_ready) begin
        if (ack_chk && !drv_ack) begin
          set_nack = 1'b1;
          state_nx = ERR_STOP;
        end else begin
          state_nx = step_next;
        end
      end else if (timed_out) begin
        set_to   = 1'b1;
        state_nx = ERR_STOP;
      end
    end
  end

endmodule

// File: tb/tb_adt7420_read_sequencer.sv
// tb/tb_adt7420_read_sequencer.sv - directed self-checking bench for adt7420_read_sequencer.
// Build with AUTO_POLL_EN defined to run the auto-poll scenario instead of the directed steps.
module tb_adt7420_read_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic [1:0]  drv_step;
  logic [7:0]  drv_tx_byte;
  logic        drv_rx_nack;
  logic        drv_ready = 1'b0;
  logic        drv_ack = 1'b0;
  logic [7:0]  drv_rx_byte = 8'h00;
  logic [15:0] temp_raw;
  logic        temp_valid;
  logic        nack_err;
  logic        timeout_err;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  adt7420_read_sequencer #(
    .DEV_ADDR      (7'h48),
    .REG_ADDR      (8'h00),
    .TIMEOUT_CYCLES(20'd50),
    .POLL_CYCLES   (24'd2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .drv_step    (drv_step),
    .drv_tx_byte (drv_tx_byte),
    .drv_rx_nack (drv_rx_nack),
    .drv_ready   (drv_ready),
    .drv_ack     (drv_ack),
    .drv_rx_byte (drv_rx_byte),
    .temp_raw    (temp_raw),
    .temp_valid  (temp_valid),
    .nack_err    (nack_err),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge: verify the pending command, optionally stall, then complete it.
  task automatic serve(input string tag, input logic [1:0] st, input logic [7:0] b, input logic n,
                       input logic a, input logic [7:0] rx, input int dly);
    chk({tag, "_step"}, {30'd0, drv_step}, {30'd0, st});
    if (st == 2'b10) chk({tag, "_byte"}, {24'd0, drv_tx_byte}, {24'd0, b});
    if (st == 2'b11) chk({tag, "_nack"}, {31'd0, drv_rx_nack}, {31'd0, n});
    repeat (dly) @(negedge clk);
    if (dly > 0) chk({tag, "_hold"}, {30'd0, drv_step}, {30'd0, st});
    drv_ready   = 1'b1;
    drv_ack     = a;
    drv_rx_byte = rx;
    @(negedge clk);
    drv_ready   = 1'b0;
    drv_ack     = 1'b0;
    drv_rx_byte = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic full_read(input string tag, input logic [7:0] m, input logic [7:0] l, input int dly);
    pulse_start();
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    serve({tag, "_s1"}, 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, dly);
    serve({tag, "_wa"}, 2'b10, 8'h90, 1'b0, 1'b1, 8'h00, 0);
    serve({tag, "_wr"}, 2'b10, 8'h00, 1'b0, 1'b1, 8'h00, dly);
    serve({tag, "_s2"}, 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve({tag, "_ra"}, 2'b10, 8'h91, 1'b0, 1'b1, 8'h00, 0);
    serve({tag, "_rm"}, 2'b11, 8'h00, 1'b0, 1'b1, m, dly);
    serve({tag, "_rl"}, 2'b11, 8'h00, 1'b1, 1'b1, l, 0);
    chk({tag, "_stop_step"}, {30'd0, drv_step}, 32'd0);
    chk({tag, "_stop_tv"}, {31'd0, temp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_tv"}, {31'd0, temp_valid}, 32'd1);
    chk({tag, "_done_raw"}, {16'd0, temp_raw}, {16'd0, m, l});
    @(negedge clk);
    chk({tag, "_idle_tv"}, {31'd0, temp_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

`ifdef AUTO_POLL_EN
  int tv_cnt = 0;
  int tv_t0  = 0;
  int tv_t1  = 0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4600; c++) begin
      @(negedge clk);
      if (temp_valid) begin
        if (tv_cnt == 0) tv_t0 = c;
        if (tv_cnt == 1) tv_t1 = c;
        tv_cnt++;
      end
      drv_ready   = (drv_step != 2'b00);
      drv_ack     = 1'b1;
      drv_rx_byte = 8'h5A;
    end
    drv_ready = 1'b0;
    chk("poll_pulses", tv_cnt, 2);
    chk("poll_spacing", tv_t1 - tv_t0, 2000);
    chk("poll_raw", {16'd0, temp_raw}, 32'h5A5A);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
`else
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_step", {30'd0, drv_step}, 32'd0);
    chk("rst_byte", {24'd0, drv_tx_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_raw", {16'd0, temp_raw}, 32'd0);
    chk("rst_errs", {30'd0, nack_err, timeout_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal read
    full_read("norm", 8'h0C, 8'h80, 0);

    // Address NACK
    pulse_start();
    serve("nk_s1", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("nk_wa", 2'b10, 8'h90, 1'b0, 1'b0, 8'h00, 0);
    chk("nk_err", {31'd0, nack_err}, 32'd1);
    chk("nk_stop", {30'd0, drv_step}, 32'd0);
    chk("nk_busy", {31'd0, busy}, 32'd1);
    chk("nk_tv", {31'd0, temp_valid}, 32'd0);
    @(negedge clk);
    chk("nk_idle", {31'd0, busy}, 32'd0);
    chk("nk_tv2", {31'd0, temp_valid}, 32'd0);
    chk("nk_raw", {16'd0, temp_raw}, 32'h0C80);
    chk("nk_sticky", {31'd0, nack_err}, 32'd1);

    // Timeout on the read address
    pulse_start();
    chk("to_clear", {31'd0, nack_err}, 32'd0);
    serve("to_s1", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("to_wa", 2'b10, 8'h90, 1'b0, 1'b1, 8'h00, 0);
    serve("to_wr", 2'b10, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("to_s2", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    chk("to_ra_byte", {24'd0, drv_tx_byte}, 32'h91);
    repeat (49) @(negedge clk);
    chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
    chk("to_still_ra", {30'd0, drv_step}, 32'd2);
    @(negedge clk);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_stop", {30'd0, drv_step}, 32'd0);
    @(negedge clk);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_raw", {16'd0, temp_raw}, 32'h0C80);

    // Start while busy and start during DONE are both dropped
    pulse_start();
    chk("sb_clear", {31'd0, timeout_err}, 32'd0);
    serve("sb_s1", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("sb_wa", 2'b10, 8'h90, 1'b0, 1'b1, 8'h00, 0);
    serve("sb_wr", 2'b10, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("sb_s2", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("sb_ra", 2'b10, 8'h91, 1'b0, 1'b1, 8'h00, 0);
    pulse_start();
    serve("sb_rm", 2'b11, 8'h00, 1'b0, 1'b1, 8'h12, 0);
    serve("sb_rl", 2'b11, 8'h00, 1'b1, 1'b1, 8'h34, 0);
    @(negedge clk);
    chk("sb_done_tv", {31'd0, temp_valid}, 32'd1);
    chk("sb_raw", {16'd0, temp_raw}, 32'h1234);
    pulse_start();
    chk("sb_idle_busy", {31'd0, busy}, 32'd0);
    chk("sb_no_start", {30'd0, drv_step}, 32'd0);
    chk("sb_tv_once", {31'd0, temp_valid}, 32'd0);
    @(negedge clk);
    chk("sb_stay_idle", {31'd0, busy}, 32'd0);

    // Reset during RXLSB
    pulse_start();
    serve("rr_s1", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("rr_wa", 2'b10, 8'h90, 1'b0, 1'b1, 8'h00, 0);
    serve("rr_wr", 2'b10, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("rr_s2", 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 0);
    serve("rr_ra", 2'b10, 8'h91, 1'b0, 1'b1, 8'h00, 0);
    serve("rr_rm", 2'b11, 8'h00, 1'b0, 1'b1, 8'hAA, 0);
    chk("rr_in_lsb", {30'd0, drv_step, 1'b0, drv_rx_nack}, 32'h0000000D);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_step", {30'd0, drv_step}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_raw", {16'd0, temp_raw}, 32'd0);
    chk("rr_nack", {31'd0, drv_rx_nack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    full_read("fresh", 8'h19, 8'h40, 2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
`endif

endmodule
